// File: rtl/sprite_line_engine.sv
// Per-scanline sprite engine: scans the object table during hblank, latches the
// ROM rows of intersecting objects into slots, then resolves pixels at draw time.
module sprite_line_engine #(
    parameter int         NUM_OBJ     = 8,
    parameter int         SPR_SIZE    = 32,
    parameter logic [7:0] TRANSP_MASK = 8'b0001_1111
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        obj_we,
    input  logic [2:0]  obj_idx,
    input  logic        obj_en,
    input  logic [2:0]  obj_type,
    input  logic [9:0]  obj_x,
    input  logic [9:0]  obj_y,
    input  logic        line_start,
    input  logic [9:0]  next_y,
    output logic [7:0]  rom_addr,
    input  logic [31:0] rom_data,
    input  logic        active,
    input  logic [9:0]  draw_x,
    output logic        pixel_valid,
    output logic [2:0]  pixel_type,
    output logic        pixel_bit,
    output logic        fetch_busy,
    output logic        overrun
);

    localparam int IDX_W = $clog2(NUM_OBJ);
    localparam int ROW_W = $clog2(SPR_SIZE);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [NUM_OBJ-1:0] tbl_en;
    logic [2:0]         tbl_type [NUM_OBJ];
    logic [9:0]         tbl_x    [NUM_OBJ];
    logic [9:0]         tbl_y    [NUM_OBJ];

    logic [0:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [9:0]         ly;
    logic [9:0]         scan_row;
    logic               scan_hit;

    logic [NUM_OBJ-1:0] slot_valid;
    logic [2:0]         slot_type [NUM_OBJ];
    logic [9:0]         slot_x    [NUM_OBJ];
    logic [31:0]        slot_bits [NUM_OBJ];

    logic               win_valid;
    logic [2:0]         win_type;
    logic               win_bit;
    logic [9:0]         col;
    logic               pix_bit;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tbl_en <= '0;
        end else if (obj_we) begin
            tbl_en[obj_idx[IDX_W-1:0]] <= obj_en;
        end
    end

    // NOTE: only the enable bits need a reset value; the payload is gated by them,
    // so it lives in a reset-free block that maps onto plain storage.
    always_ff @(posedge Clk) begin
        if (obj_we) begin
            tbl_type[obj_idx[IDX_W-1:0]] <= obj_type;
            tbl_x[obj_idx[IDX_W-1:0]]    <= obj_x;
            tbl_y[obj_idx[IDX_W-1:0]]    <= obj_y;
        end
    end

    // Unsigned wrap makes objects above the line land far outside the sprite height.
    assign scan_row   = ly - tbl_y[idx];
    assign scan_hit   = (state == ST_SCAN) && tbl_en[idx] && (scan_row < 10'(SPR_SIZE));
    assign rom_addr   = scan_hit ? {tbl_type[idx], scan_row[ROW_W-1:0]} : 8'd0;
    assign fetch_busy = (state == ST_SCAN);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            ly      <= '0;
            overrun <= 1'b0;
        end else if (line_start) begin
            if (state == ST_SCAN) overrun <= 1'b1;
            state <= ST_SCAN;
            idx   <= '0;
            ly    <= next_y;
        end else if (state == ST_SCAN) begin
            if (idx == IDX_W'(NUM_OBJ - 1)) begin
                state <= ST_IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_valid <= '0;
        end else if (state == ST_SCAN) begin
            slot_valid[idx] <= scan_hit;
        end
    end

    always_ff @(posedge Clk) begin
        if (scan_hit) begin
            slot_type[idx] <= tbl_type[idx];
            slot_x[idx]    <= tbl_x[idx];
            slot_bits[idx] <= rom_data;
        end
    end

    // NOTE: every variable gets a default before the loop so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        win_valid = 1'b0;
        win_type  = '0;
        win_bit   = 1'b0;
        col       = '0;
        pix_bit   = 1'b0;
        // Walk from the highest index down so the lowest opaque slot is written last.
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            col     = draw_x - slot_x[i];
            pix_bit = slot_bits[i][ROW_W'(SPR_SIZE - 1) - col[ROW_W-1:0]];
            if (slot_valid[i] && (col < 10'(SPR_SIZE)) &&
                (pix_bit || !TRANSP_MASK[slot_type[i]])) begin
                win_valid = 1'b1;
                win_type  = slot_type[i];
                win_bit   = pix_bit;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_valid <= 1'b0;
            pixel_type  <= '0;
            pixel_bit   <= 1'b0;
        end else if (active && !fetch_busy && win_valid) begin
            pixel_valid <= 1'b1;
            pixel_type  <= win_type;
            pixel_bit   <= win_bit;
        end else begin
            pixel_valid <= 1'b0;
            pixel_type  <= '0;
            pixel_bit   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine with a per-cycle behavioural reference
// model of the object table, line snapshot and pixel resolution.
module tb_sprite_line_engine;

    localparam int NUM = 8;

    logic        Clk;
    logic        Reset_n;
    logic        obj_we;
    logic [2:0]  obj_idx;
    logic        obj_en;
    logic [2:0]  obj_type;
    logic [9:0]  obj_x;
    logic [9:0]  obj_y;
    logic        line_start;
    logic [9:0]  next_y;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        active;
    logic [9:0]  draw_x;
    logic        pixel_valid;
    logic [2:0]  pixel_type;
    logic        pixel_bit;
    logic        fetch_busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    sprite_line_engine dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .obj_we(obj_we), .obj_idx(obj_idx), .obj_en(obj_en), .obj_type(obj_type),
        .obj_x(obj_x), .obj_y(obj_y),
        .line_start(line_start), .next_y(next_y),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .active(active), .draw_x(draw_x),
        .pixel_valid(pixel_valid), .pixel_type(pixel_type), .pixel_bit(pixel_bit),
        .fetch_busy(fetch_busy), .overrun(overrun)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Sprite ROM stand-in: every row word is a simple function of its address.
    function automatic logic [31:0] rom_word(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: live table, per-line snapshot, scan countdown.
    logic [7:0] m_en;
    logic [2:0] m_type [NUM];
    logic [9:0] m_x    [NUM];
    logic [9:0] m_y    [NUM];
    logic [7:0] snap_en;
    logic [2:0] snap_type [NUM];
    logic [9:0] snap_x    [NUM];
    logic [9:0] snap_y    [NUM];
    logic [9:0] line_ly;
    int         busy_cnt;
    logic       exp_ovr;
    logic [4:0] exp_pix;

    // Returns {valid, type[2:0], bit} for a column on the snapshotted line.
    function automatic logic [4:0] model_pixel(input logic [9:0] dx);
        int row;
        int cl;
        logic [31:0] w;
        logic pb;
        for (int i = 0; i < NUM; i++) begin
            row = (int'(line_ly) - int'(snap_y[i]) + 1024) % 1024;
            cl  = (int'(dx) - int'(snap_x[i]) + 1024) % 1024;
            if (snap_en[i] && row < 32 && cl < 32) begin
                w  = rom_word(8'(int'(snap_type[i]) * 32 + row));
                pb = w[31 - cl];
                if (pb || snap_type[i] > 3'd4) return {1'b1, snap_type[i], pb};
            end
        end
        return 5'b0;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_cnt <= 0;
            exp_ovr  <= 1'b0;
            exp_pix  <= '0;
            m_en     <= '0;
            snap_en  <= '0;
            line_ly  <= '0;
        end else begin
            exp_pix <= (active && busy_cnt == 0) ? model_pixel(draw_x) : 5'b0;
            if (obj_we) begin
                m_en[obj_idx]   <= obj_en;
                m_type[obj_idx] <= obj_type;
                m_x[obj_idx]    <= obj_x;
                m_y[obj_idx]    <= obj_y;
            end
            if (line_start) begin
                if (busy_cnt > 0) exp_ovr <= 1'b1;
                busy_cnt  <= NUM;
                line_ly   <= next_y;
                snap_en   <= m_en;
                snap_type <= m_type;
                snap_x    <= m_x;
                snap_y    <= m_y;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    always @(negedge Clk) begin
        int pos;
        int r;
        if (chk_en) begin
            check("pixel_valid", {31'b0, pixel_valid}, {31'b0, exp_pix[4]});
            check("pixel_type", {29'b0, pixel_type}, {29'b0, exp_pix[3:1]});
            check("pixel_bit", {31'b0, pixel_bit}, {31'b0, exp_pix[0]});
            check("fetch_busy", {31'b0, fetch_busy}, {31'b0, busy_cnt != 0});
            check("overrun", {31'b0, overrun}, {31'b0, exp_ovr});
            if (busy_cnt == 0) begin
                check("rom_addr_idle", {24'b0, rom_addr}, 32'd0);
            end else begin
                pos = NUM - busy_cnt;
                r   = (int'(line_ly) - int'(m_y[pos]) + 1024) % 1024;
                if (m_en[pos] && r < 32)
                    check("rom_addr_scan", {24'b0, rom_addr}, 32'(int'(m_type[pos]) * 32 + r));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_obj(input int i, input logic en, input logic [2:0] t,
                             input logic [9:0] x, input logic [9:0] y);
        obj_we = 1'b1; obj_idx = 3'(i); obj_en = en; obj_type = t; obj_x = x; obj_y = y;
        tick();
        obj_we = 1'b0;
    endtask

    task automatic line(input logic [9:0] y);
        next_y = y; line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_scan(input int start, input string name);
        int n = start;
        while (fetch_busy && n < 40) begin
            n++;
            tick();
        end
        check(name, 32'(n), 32'd8);
    endtask

    task automatic pix(input logic [9:0] dx, input logic v, input logic [2:0] t,
                       input logic b, input string name);
        draw_x = dx; active = 1'b1;
        tick();
        check({name, "_valid"}, {31'b0, pixel_valid}, {31'b0, v});
        check({name, "_type"}, {29'b0, pixel_type}, {29'b0, t});
        check({name, "_bit"}, {31'b0, pixel_bit}, {31'b0, b});
        active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic any_valid;
        Reset_n = 1'b1; obj_we = 1'b0; obj_idx = '0; obj_en = 1'b0; obj_type = '0;
        obj_x = '0; obj_y = '0; line_start = 1'b0; next_y = '0; active = 1'b0; draw_x = '0;
        #2 Reset_n = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_pixel_valid", {31'b0, pixel_valid}, 32'd0);
        check("reset_fetch_busy", {31'b0, fetch_busy}, 32'd0);
        check("reset_overrun", {31'b0, overrun}, 32'd0);
        check("reset_rom_addr", {24'b0, rom_addr}, 32'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        // 1: empty table, full scan and line sweep
        line(10'd50);
        n = 0;
        while (fetch_busy && n < 40) begin
            check("t1_rom_addr", {24'b0, rom_addr}, 32'd0);
            n++;
            tick();
        end
        check("t1_busy_cycles", 32'(n), 32'd8);
        any_valid = 1'b0;
        for (int i = 0; i < 640; i++) begin
            draw_x = 10'(i); active = 1'b1;
            tick();
            any_valid = any_valid | pixel_valid;
        end
        active = 1'b0;
        check("t1_no_pixels", {31'b0, any_valid}, 32'd0);

        // 2: single tank
        write_obj(0, 1'b1, 3'd0, 10'd100, 10'd50);
        line(10'd50);
        check("t2_rom_addr_c0", {24'b0, rom_addr}, 32'd0);
        wait_scan(0, "t2_busy_cycles");
        pix(10'd114, 1'b1, 3'd0, 1'b1, "t2_x114");
        pix(10'd100, 1'b0, 3'd0, 1'b0, "t2_x100");
        pix(10'd132, 1'b0, 3'd0, 1'b0, "t2_x132");

        // 3: brick at entry 2, line 60
        write_obj(2, 1'b1, 3'd5, 10'd0, 10'd50);
        line(10'd60);
        tick();
        tick();
        check("t3_rom_addr_c2", {24'b0, rom_addr}, 32'd170);
        wait_scan(2, "t3_busy_cycles");
        pix(10'd8, 1'b1, 3'd5, 1'b0, "t3_x8");
        pix(10'd104, 1'b1, 3'd0, 1'b1, "t3_x104");

        // 4: overlapping tank and brick on line 50
        write_obj(1, 1'b1, 3'd5, 10'd100, 10'd50);
        line(10'd50);
        wait_scan(0, "t4_busy_cycles");
        pix(10'd114, 1'b1, 3'd0, 1'b1, "t4_x114");
        pix(10'd100, 1'b1, 3'd5, 1'b1, "t4_x100");
        pix(10'd104, 1'b1, 3'd5, 1'b0, "t4_x104");

        // 5: restart at scan cycle 3 onto line 60
        line(10'd50);
        tick();
        tick();
        tick();
        line(10'd60);
        check("t5_overrun", {31'b0, overrun}, 32'd1);
        wait_scan(0, "t5_busy_cycles");
        pix(10'd104, 1'b1, 3'd0, 1'b1, "t5_x104");
        pix(10'd8, 1'b1, 3'd5, 1'b0, "t5_x8");

        // 5b: object far below wraps to a large row, never hit
        write_obj(3, 1'b1, 3'd7, 10'd300, 10'd630);
        line(10'd5);
        wait_scan(0, "t5b_busy_cycles");
        pix(10'd310, 1'b0, 3'd0, 1'b0, "t5b_wrap");

        // 6: asynchronous reset mid-scan
        line(10'd50);
        tick();
        tick();
        #3 Reset_n = 1'b0;
        #1;
        check("t6_fetch_busy", {31'b0, fetch_busy}, 32'd0);
        check("t6_overrun", {31'b0, overrun}, 32'd0);
        check("t6_pixel_valid", {31'b0, pixel_valid}, 32'd0);
        check("t6_rom_addr", {24'b0, rom_addr}, 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        line(10'd50);
        wait_scan(0, "t6_busy_cycles");
        pix(10'd114, 1'b0, 3'd0, 1'b0, "t6_x114");
        pix(10'd100, 1'b0, 3'd0, 1'b0, "t6_x100");

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_line_engine.md
Name: sprite_line_engine

Overview:
Per-scanline sprite fetch and pixel engine that sits directly downstream of the 256x32 sprite bitmap ROM. It holds a small object table written by game logic. At each line_start (horizontal blank) it scans the table, drives the ROM address of every object that intersects the next line, and latches those 32-bit rows into slot registers. During active video it resolves draw_x against the slots and emits the winning object's type and bitmap bit to the colour mapper.

Parameters:
NUM_OBJ, 8, object table entries / line slots (power of 2, max 8)
SPR_SIZE, 32, sprite width and height in pixels (fixed by ROM layout)
TRANSP_MASK, 8'b0001_1111, bit t=1 means a 0 pixel of ROM type t is transparent (tanks 0-3, bullet 4)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
obj_we  in  1  object table write strobe
obj_idx  in  3  entry to write
obj_en  in  1  entry enable
obj_type  in  3  sprite type, ROM block: 0-3 tank U/L/D/R, 4 bullet, 5 brick, 6 bush, 7 rock
obj_x  in  10  left column
obj_y  in  10  top row
line_start  in  1  one-cycle pulse at start of hblank
next_y  in  10  line about to be displayed, sampled on line_start
rom_addr  out  8  {type, row} to sprite ROM
rom_data  in  32  ROM row, combinational, MSB = leftmost pixel
active  in  1  draw_x is a visible pixel this cycle
draw_x  in  10  current pixel column
pixel_valid  out  1  an opaque object covers the pixel
pixel_type  out  3  type of winning object
pixel_bit  out  1  ROM bit of winning object
fetch_busy  out  1  scan in progress
overrun  out  1  sticky error flag

Behaviour:
- Reset (async, Reset_n=0): all table enables, slot valids, outputs and overrun to 0; rom_addr=0; FSM to IDLE.
- Table writes: registered on obj_we and visible to the scan from the next cycle. Writes are allowed at any time.
- FSM IDLE: rom_addr=0. On line_start, latch next_y into ly, idx=0, and go to SCAN.
- FSM SCAN: one entry per cycle. row = ly - obj_y[idx], unsigned 10-bit.
  - If en and row<32: rom_addr={type,row[4:0]}; at the clock edge store slot[idx] = {valid=1, x, type, bits=rom_data}.
  - Otherwise slot[idx].valid=0.
  - After idx=NUM_OBJ-1, return to IDLE. fetch_busy=1 for exactly NUM_OBJ cycles.
- No vertical wrap: obj_y=630, ly=5 gives row=399, so no hit.
- line_start during SCAN: set overrun, relatch next_y, restart from idx=0. overrun clears only on reset.
- Pixel path, registered, latency 1: inputs at cycle t produce outputs at t+1.
  - col = draw_x - slot.x, unsigned 10-bit. A slot hits if valid and col<32.
  - bit = bits[31-col]. A hit is opaque unless bit=0 and TRANSP_MASK[type]=1.
  - The lowest-index opaque slot wins and drives pixel_valid=1 with its pixel_type and pixel_bit.
  - With no opaque winner, or active=0, or fetch_busy=1: pixel_valid=0, pixel_type=0, pixel_bit=0.
- Slots persist until overwritten by the next scan, so each line shows the objects fetched for it.

Test Plan:
1. Reset, table empty, line_start next_y=50, sweep draw_x 0-639 -> fetch_busy high exactly 8 cycles, rom_addr=0 throughout, pixel_valid=0 everywhere.
2. obj0 {en,type0,x=100,y=50}, line_start next_y=50 -> rom_addr=8'd0 in scan cycle 0. Then draw_x=114 gives pixel_valid=1, type=0, bit=1 one cycle later; draw_x=100 gives pixel_valid=0 (transparent); draw_x=132 gives pixel_valid=0.
3. obj2 {type5,x=0,y=50}, next_y=60 -> rom_addr=8'd170 in scan cycle 2. draw_x=8 gives valid=1, type=5, bit=0 (brick non-transparent).
4. Overlap at y=50: obj0 tank-up x=100, obj1 brick x=100 -> draw_x=114 gives type 0; draw_x=100 gives type 5, bit 1.
5. line_start pulsed again at scan cycle 3 -> overrun=1, scan restarts, fetch_busy stays high 8 cycles after the second pulse, slots reflect the second next_y.
6. Reset_n low mid-scan without a clock edge -> outputs, overrun and fetch_busy go to 0 immediately. After release, the first line_start scans with all entries disabled.
